// File: rtl/display_serial_driver.sv
// Turns binary hh:mm:ss into six 7-segment bytes and shifts them out MSB-first
// to an external shift-register chain, followed by a storage-latch pulse.
module display_serial_driver #(
  parameter int SYS_CLK_HZ   = 5_000_000,
  parameter int SHIFT_CLK_HZ = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_start,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_seconds,
  input  logic       i_colon,
  output logic       o_serial_data,
  output logic       o_serial_clk,
  output logic       o_serial_latch,
  output logic       o_busy,
  output logic       o_done
);

  localparam int HALF_RAW = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int PW       = (2 * HALF <= 2) ? 1 : $clog2(2 * HALF);

  localparam logic [PW-1:0] PH_LAST  = PW'(2 * HALF - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(HALF);
  localparam logic [PW-1:0] LAT_LAST = PW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t          state;
  logic [47:0]     shreg;
  logic [5:0]      bitcnt;
  logic [PW-1:0]   phase;
  logic [47:0]     frame;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Tens byte never carries a decimal point; the ones byte gets dp.
  function automatic logic [15:0] digit_pair(input logic [5:0] v, input logic dp);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
    digit_pair = {1'b0, seg7(tens), dp, seg7(ones)};
  endfunction

  assign frame = {digit_pair({1'b0, i_hours}, i_colon),
                  digit_pair(i_minutes, i_colon),
                  digit_pair(i_seconds, 1'b0)};

  // The current bit always sits in shreg[47]; 48 shifts leave it all-zero.
  assign o_serial_data = shreg[47];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      shreg          <= '0;
      bitcnt         <= '0;
      phase          <= '0;
      o_serial_clk   <= 1'b0;
      o_serial_latch <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state != IDLE && !i_en) begin
        state          <= IDLE;
        shreg          <= '0;
        bitcnt         <= '0;
        phase          <= '0;
        o_serial_clk   <= 1'b0;
        o_serial_latch <= 1'b0;
        o_busy         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start && i_en) begin
              state  <= LOAD;
              o_busy <= 1'b1;
            end
          end
          LOAD: begin
            shreg        <= frame;
            bitcnt       <= 6'd47;
            phase        <= '0;
            o_serial_clk <= 1'b0;
            state        <= SHIFT;
          end
          SHIFT: begin
            if (phase == PH_LAST) begin
              phase        <= '0;
              o_serial_clk <= 1'b0;
              shreg        <= {shreg[46:0], 1'b0};
              if (bitcnt == 6'd0) begin
                state          <= LATCH;
                o_serial_latch <= 1'b1;
              end else begin
                bitcnt <= bitcnt - 6'd1;
              end
            end else begin
              phase        <= phase + 1'b1;
              o_serial_clk <= ((phase + 1'b1) >= PH_HALF);
            end
          end
          LATCH: begin
            if (phase == LAT_LAST) begin
              state          <= IDLE;
              phase          <= '0;
              o_serial_latch <= 1'b0;
              o_busy         <= 1'b0;
              o_done         <= 1'b1;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_serial_driver.sv
// Directed bench: per-cycle comparison of the serial outputs against a
// cycle-timing model built from the expected 48-bit frame.
module tb_display_serial_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       start;
  logic       start1;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       colon;

  logic sd0, sc0, sl0, b0, d0;
  logic sd1, sc1, sl1, b1, d1;

  bit   sel;
  logic [4:0] mon;
  assign mon = sel ? {b1, d1, sl1, sc1, sd1} : {b0, d0, sl0, sc0, sd0};

  int checks = 0;
  int errors = 0;

  display_serial_driver dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_start(start),
    .i_hours(hours), .i_minutes(minutes), .i_seconds(seconds), .i_colon(colon),
    .o_serial_data(sd0), .o_serial_clk(sc0), .o_serial_latch(sl0),
    .o_busy(b0), .o_done(d0)
  );

  display_serial_driver #(.SYS_CLK_HZ(5_000_000), .SHIFT_CLK_HZ(5_000_000)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_start(start1),
    .i_hours(hours), .i_minutes(minutes), .i_seconds(seconds), .i_colon(colon),
    .o_serial_data(sd1), .o_serial_clk(sc1), .o_serial_latch(sl1),
    .o_busy(b1), .o_done(d1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic        colon;
    logic [47:0] frame;
    int          half;
    bit          use1;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {busy, done, latch, clk, data} in cycle N+c after start at N.
  function automatic logic [4:0] model(input int c, input int h, input logic [47:0] f);
    int idx;
    int ph;
    if (c == 1) return 5'b10000;
    if (c >= 2 && c < 2 + 96 * h) begin
      idx = (c - 2) / (2 * h);
      ph  = (c - 2) % (2 * h);
      return {1'b1, 1'b0, 1'b0, (ph >= h), f[47 - idx]};
    end
    if (c >= 2 + 96 * h && c < 2 + 97 * h) return 5'b10100;
    if (c == 2 + 97 * h) return 5'b01000;
    return 5'b00000;
  endfunction

  task automatic check5(input string name, input int c, input logic [4:0] want);
    checks++;
    if (mon !== want) begin
      errors++;
      $display("FAIL %s cycle N+%0d (busy,done,latch,clk,data) got %b want %b",
               name, c, mon, want);
    end
  endtask

  task automatic run_frame(input vec_t v, input int pulse_at, input int drop_at, input int tag);
    logic [47:0] got;
    logic        prev;
    logic [4:0]  want;
    string       name;
    int          last;
    name = $sformatf("frame%0d", tag);
    hours = v.h; minutes = v.m; seconds = v.s; colon = v.colon;
    sel = v.use1;
    if (v.use1) start1 = 1'b1; else start = 1'b1;
    got  = '0;
    prev = 1'b0;
    last = 2 + 97 * v.half + 4;
    for (int c = 1; c <= last; c++) begin
      tick();
      start  = 1'b0;
      start1 = 1'b0;
      if (c == 2) begin
        hours = ~hours; minutes = ~minutes; seconds = ~seconds; colon = ~colon;
      end
      if (c == pulse_at) begin
        if (v.use1) start1 = 1'b1; else start = 1'b1;
      end
      if (drop_at >= 0 && c >= drop_at) en = 1'b0;
      if (drop_at >= 0 && c > drop_at) want = 5'b00000;
      else want = model(c, v.half, v.frame);
      check5(name, c, want);
      if (mon[1] && !prev) got = {got[46:0], mon[0]};
      prev = mon[1];
    end
    en = 1'b1;
    if (drop_at < 0) begin
      checks++;
      if (got !== v.frame) begin
        errors++;
        $display("FAIL %s_bytes got %h want %h", name, got, v.frame);
      end
    end
  endtask

  initial begin
    vecs[0] = '{5'd12, 6'd34, 6'd56, 1'b1, 48'h06DB4FE66D7D, 2, 1'b0};
    vecs[1] = '{5'd0,  6'd0,  6'd0,  1'b0, 48'h3F3F3F3F3F3F, 2, 1'b0};
    vecs[2] = '{5'd31, 6'd63, 6'd9,  1'b0, 48'h4F067D4F3F6F, 2, 1'b0};
    vecs[3] = '{5'd23, 6'd59, 6'd48, 1'b1, 48'h5BCF6DEF667F, 2, 1'b0};
    vecs[4] = '{5'd7,  6'd18, 6'd20, 1'b0, 48'h3F07067F5B3F, 2, 1'b0};
    vecs[5] = '{5'd0,  6'd0,  6'd0,  1'b1, 48'h3FBF3FBF3F3F, 2, 1'b0};
    vecs[6] = '{5'd12, 6'd34, 6'd56, 1'b1, 48'h06DB4FE66D7D, 1, 1'b1};
    vecs[7] = '{5'd31, 6'd63, 6'd9,  1'b0, 48'h4F067D4F3F6F, 1, 1'b1};

    rst_n = 1'b0; en = 1'b1; start = 1'b0; start1 = 1'b0;
    hours = '0; minutes = '0; seconds = '0; colon = 1'b0; sel = 1'b0;
    repeat (3) tick();
    check5("reset_dut", 0, 5'b00000);
    sel = 1'b1;
    #1;
    check5("reset_dut1", 0, 5'b00000);
    sel = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], -1, -1, i);
      tick();
    end

    // Start pulse mid-frame must be ignored; a later start runs a fresh frame.
    run_frame(vecs[0], 50, -1, 10);
    run_frame(vecs[3], -1, -1, 11);

    // Enable dropped mid-frame aborts silently.
    run_frame(vecs[2], -1, 100, 12);
    en = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      check5("start_while_disabled", c, 5'b00000);
    end
    en = 1'b1;
    tick();

    // Asynchronous reset in the middle of a shift, while serial clk is high.
    sel = 1'b0;
    hours = 5'd12; minutes = 6'd34; seconds = 6'd56; colon = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (31) tick();
    checks++;
    if (mon[4:1] !== 4'b1001) begin
      errors++;
      $display("FAIL pre_reset_state got %b want 1001x", mon);
    end
    #2 rst_n = 1'b0;
    #1 check5("async_reset", 32, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check5("idle_after_reset", c, 5'b00000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_serial_driver.md
# display_serial_driver

Converts the current time (binary hours, minutes, seconds) into six 7-segment digit patterns and shifts them out as a 48-bit serial frame. The frame goes to the external shift-register display chain on data/clock/latch pins. The block sits inside the clock core, directly upstream of the top-level `serial_data`/`serial_latch`/`serial_clk` output pins. It consumes the time registers and a refresh request from the timekeeping logic.

## Interface
- `SYS_CLK_HZ`, 5_000_000: system clock frequency.
- `SHIFT_CLK_HZ`, 1_000_000: target serial clock frequency. HALF = max(1, SYS_CLK_HZ/(2*SHIFT_CLK_HZ)), integer division. Default HALF = 2, giving a 1.25 MHz serial clock.

Ports:
- `i_clk` in 1: system clock. One clock only.
- `i_reset_n` in 1: reset, asynchronous, active-low.
- `i_en` in 1: block enable. Low aborts any frame and blocks new ones.
- `i_start` in 1: refresh request, one-cycle pulse. Accepted only in IDLE with `i_en`=1.
- `i_hours` in 5: binary hours, 0–31.
- `i_minutes` in 6: binary minutes, 0–63.
- `i_seconds` in 6: binary seconds, 0–63.
- `i_colon` in 1: lights the decimal point of the hours-ones and minutes-ones digits.
- `o_serial_data` out 1: serial data, MSB of frame first.
- `o_serial_clk` out 1: serial shift clock. The display samples on the rising edge.
- `o_serial_latch` out 1: storage latch pulse, active high.
- `o_busy` out 1: high from LOAD through the end of LATCH.
- `o_done` out 1: one-cycle pulse when a frame completes normally.

## Operation
- FSM states: IDLE, LOAD, SHIFT, LATCH.
- IDLE → LOAD when `i_start`=1 and `i_en`=1. In LOAD the inputs are captured, then BCD-converted and encoded into a 48-bit shift register. Inputs are don't-care after LOAD.
- BCD conversion: tens = v/10, ones = v%10, done arithmetically for the full input range with no range checking. Examples: 63 → 6,3; 31 → 3,1.
- Frame order, first byte shifted first: H-tens, H-ones, M-tens, M-ones, S-tens, S-ones.
- Byte format: bit7 = dp, bits6..0 = g,f,e,d,c,b,a. Segments are active-high. No leading-zero blanking.
- dp = `i_colon` on H-ones and M-ones; dp = 0 on all other digits.
- Segment codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- SHIFT: a phase counter runs 0..2*HALF-1 for each bit.
  - `o_serial_clk` = (phase ≥ HALF).
  - `o_serial_data` holds the current bit for the whole bit period and changes only when the phase wraps, i.e. with the clock falling edge.
  - The bit counter runs from 47 down to 0.
- After bit 0's period ends, go to LATCH. In LATCH: `o_serial_latch`=1, data=0, clk=0, for HALF cycles. Then go to IDLE and pulse `o_done`.
- `i_start` while busy is ignored; it is not queued.
- `i_en`=0 in any non-IDLE state: next cycle go to IDLE. All serial outputs go low, no latch pulse, no `o_done`.
- Reset (asynchronous, any state): IDLE. All outputs are 0, and all counters and the shift register are cleared.

## Timing
- Reset value of every output is 0.
- Outputs are registered: no combinational path from inputs to outputs.
- `i_start` sampled at cycle N:
  - Cycle N+1: LOAD, `o_busy`=1.
  - Cycle N+2: SHIFT begins; bit47 is on data and clk=0.
- Bit k (k = 47..0) occupies cycles N+2+(47−k)*2*HALF onward: clk low for HALF cycles, then high for HALF cycles.
- LATCH starts at N+2+96*HALF and lasts HALF cycles.
- `o_done`=1 and `o_busy`=0 at N+2+97*HALF. With defaults: latch at N+194–N+195, done at N+196.
- A new `i_start` can be accepted in the same cycle `o_done` is high, since the FSM is in IDLE then.

## Test plan
- Reset: assert `i_reset_n`=0 mid-SHIFT → all outputs 0 immediately (asynchronously). After release, `o_busy` stays 0 until `i_start`.
- Frame 12:34:56, `i_colon`=1, defaults → shifted bytes 06, DB, 4F, E6, 6D, 7D (MSB first). Latch high on cycles N+194–N+195; `o_done` pulses at N+196. Each rising edge of `o_serial_clk` must be HALF=2 cycles after a data change.
- Frame 00:00:00, `i_colon`=0 → six bytes of 3F. Range check: 31:63:09 → 03? No: H-tens=4F(3), H-ones=06(1), M-tens=7D(6), M-ones=4F(3), S-tens=3F(0), S-ones=6F(9).
- `i_start` pulsed at cycle N+50 during a frame → ignored. Exactly one `o_done`, and a second `i_start` after done starts a fresh frame.
- `i_en` dropped at N+100 → outputs low at N+101, no latch pulse, no `o_done`, FSM in IDLE. `i_start` with `i_en`=0 → no activity.
- `SHIFT_CLK_HZ`=SYS_CLK_HZ (HALF=1) → clock toggles every cycle; done at N+99.
